prog_loader: RTL and testbench
==============================

# prog_loader

Host-side program loader and run sequencer for the 9-bit-instruction core. It accepts a valid/ready stream of machine-code words and writes them into the write port of the instruction memory, starting at address 0. On request it pulses the core's `start`, waits for `done`, and reports the execution cycle count. It sits between the bench or host and the core top level, and owns the core's `start` line.

## Interface
Parameters:
- `D`, 12, instruction address width; matches the core's program counter width.
- `W`, 9, instruction word width.
- `CW`, 16, cycle-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `clear` in 1: synchronous return to IDLE; highest priority in every state.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader can accept a word.
- `s_data` in W: machine-code word.
- `s_last` in 1: marks the final word of the program.
- `run_req` in 1: request execution of the loaded program.
- `im_wr_en` out 1: instruction-memory write strobe.
- `im_wr_addr` out D: write address.
- `im_wr_data` out W: write data.
- `core_start` out 1: drives the core's `start`.
- `core_done` in 1: the core's `done` (halt).
- `load_count` out D+1: number of words written.
- `load_ovf` out 1: sticky flag; the program filled memory without `s_last`.
- `cycle_count` out CW: run length in cycles.
- `busy` out 1: high in START and RUN.
- `finished` out 1: high in DONE.
- `timeout` out 1: high in TIMEOUT.

## Operation
- States: IDLE, LOAD, ARMED, START, RUN, DONE, TIMEOUT.
- Handshake: a beat transfers when `s_valid & s_ready`. `s_ready` = 1 only in IDLE and LOAD.
- IDLE behaviour:
  - `load_count` = 0 and the write pointer = 0.
  - The first beat is written at address 0; the next state is LOAD, or ARMED if `s_last` is set.
- LOAD: each beat is written at the pointer, then the pointer and `load_count` increment.
- Leaving LOAD for ARMED happens on either condition:
  - a beat with `s_last` = 1;
  - the beat written at address 2^D−1. This is an implicit last word and also sets `load_ovf`.
- ARMED:
  - `run_req` = 1 moves to START.
  - A new `s_valid` is ignored (`s_ready` = 0).
- START:
  - `core_start` = 1 for exactly 2 cycles, which clears the core's PC and register file.
  - `cycle_count` is cleared on entry.
  - `core_done` is ignored in this state.
  - Then go to RUN.
- RUN:
  - A cycle with `core_done` = 0 increments `cycle_count`.
  - A cycle with `core_done` = 1 moves to DONE without incrementing.
- TIMEOUT: if `cycle_count` reaches 2^CW−1 while still in RUN, it holds there (saturates) and the state moves to TIMEOUT.
- DONE and TIMEOUT:
  - `cycle_count` is frozen.
  - `run_req` = 1 re-runs the same program (go to START).
  - Reloading a program requires `clear`.
- `clear` in any state:
  - Go to IDLE.
  - Zero `load_count`, `load_ovf` and the pointer.
  - `cycle_count` holds its value.
  - `core_start` deasserts immediately at the next edge, even mid-START.
- Simultaneous events:
  - `clear` beats `run_req`.
  - `clear` beats a stream beat: that beat is not accepted, because `s_ready` drops in the same cycle combinationally with `clear`.

## Timing
- Reset (`reset` = 0) drives every output to 0, the state to IDLE and `load_ovf` to 0. `s_ready` rises in the first cycle after `reset` deasserts.
- Write path latency is 1 cycle. `im_wr_en`, `im_wr_addr` and `im_wr_data` are registered from the accepting edge. `im_wr_en` is a single-cycle pulse per beat, and back-to-back beats give back-to-back writes.
- The final word's `im_wr_en` is asserted in the first ARMED cycle. `run_req` takes effect at the end of that cycle at the earliest, so the last write completes before `core_start` rises.
- Start timing:
  - `core_start` is registered.
  - It is high during the 2 START cycles.
  - The first RUN cycle immediately follows.
- `core_done` is sampled on `clk`. `finished` rises the cycle after `core_done` is first seen high in RUN.
- `cycle_count` = number of RUN cycles before the one in which `core_done` was sampled high. If done is sampled in the first RUN cycle, the count is 0.
- `busy`, `finished` and `timeout` are decoded from the state register and carry no extra latency.
- An asynchronous reset mid-LOAD or mid-RUN aborts immediately and drops `core_start`. Memory contents are not cleared.

## Test plan
- Reset, then stream 3 words 0x1A0, 0x041, 0x1FF (the last with `s_last`) -> `im_wr_en` pulses at addresses 0, 1, 2 with matching data; `load_count` = 3; state ARMED; `s_ready` = 0.
- ARMED, `run_req` pulse, bench holds `core_done` = 0 for 7 RUN cycles then 1 -> `core_start` high for exactly 2 cycles; `finished` = 1; `cycle_count` = 7.
- `core_done` held high throughout START and RUN -> done is ignored in START; `cycle_count` = 0; DONE reached.
- With D = 3, stream 8 words without `s_last` -> writes at addresses 0–7; `load_ovf` = 1; ARMED; a 9th `s_valid` is not accepted.
- With CW = 4, `core_done` never asserts -> `cycle_count` saturates at 15; `timeout` = 1; `run_req` restarts with `cycle_count` cleared.
- `clear` together with `run_req` in ARMED, and `reset` dropped mid-RUN -> IDLE both times, `core_start` stays 0, and all outputs are 0 after reset.

Source files
------------

// File: rtl/prog_loader.sv
// Loads a machine-code stream into instruction memory, then starts the core and times its run.
// Latency: writes are registered one cycle after the accepting edge; core_start is registered.
// Backpressure: s_ready is high only in IDLE/LOAD and drops combinationally while clear is high.
//
// Ports: clk/reset (async active-low)/clear (sync, top priority); s_valid/s_ready/s_data/s_last
// program stream; run_req; im_wr_en/im_wr_addr/im_wr_data instruction-memory write port;
// core_start/core_done core handshake; load_count, load_ovf, cycle_count, busy, finished, timeout status.
module prog_loader #(
    parameter int D  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    input  logic          s_last,
    input  logic          run_req,
    output logic          im_wr_en,
    output logic [D-1:0]  im_wr_addr,
    output logic [W-1:0]  im_wr_data,
    output logic          core_start,
    input  logic          core_done,
    output logic [D:0]    load_count,
    output logic          load_ovf,
    output logic [CW-1:0] cycle_count,
    output logic          busy,
    output logic          finished,
    output logic          timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARMED, S_START, S_RUN, S_DONE, S_TIMEOUT
    } state_t;

    state_t          state_q, state_d;
    logic [D-1:0]    ptr_q, ptr_d;
    logic [D:0]      load_count_q, load_count_d;
    logic            load_ovf_q, load_ovf_d;
    logic [CW-1:0]   cycle_count_q, cycle_count_d;
    logic            core_start_q, core_start_d;
    logic            start_cnt_q, start_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [D-1:0]    wr_addr_q, wr_addr_d;
    logic [W-1:0]    wr_data_q, wr_data_d;
    // Holds s_ready low while reset is asserted and until the first edge after release.
    logic            ready_en_q, ready_en_d;

    logic            beat;
    logic [CW-1:0]   cc_inc;

    assign s_ready = ready_en_q & ~clear & ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign beat    = s_valid & s_ready;
    assign cc_inc  = cycle_count_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        load_count_d  = load_count_q;
        load_ovf_d    = load_ovf_q;
        cycle_count_d = cycle_count_q;
        core_start_d  = 1'b0;
        start_cnt_d   = start_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        ready_en_d    = 1'b1;

        if (clear) begin
            // cycle_count is deliberately kept so the last run result stays readable.
            state_d      = S_IDLE;
            ptr_d        = '0;
            load_count_d = '0;
            load_ovf_d   = 1'b0;
            start_cnt_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (beat) begin
                        wr_en_d      = 1'b1;
                        wr_addr_d    = ptr_q;
                        wr_data_d    = s_data;
                        ptr_d        = ptr_q + D'(1);
                        load_count_d = load_count_q + (D+1)'(1);
                        if (s_last) begin
                            state_d = S_ARMED;
                        end else if (ptr_q == {D{1'b1}}) begin
                            // Memory is full: treat as an implicit last word.
                            state_d    = S_ARMED;
                            load_ovf_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_ARMED, S_DONE, S_TIMEOUT: begin
                    if (run_req) begin
                        state_d       = S_START;
                        core_start_d  = 1'b1;
                        start_cnt_d   = 1'b0;
                        cycle_count_d = '0;
                    end
                end
                S_START: begin
                    // Two START cycles; core_done is not looked at here.
                    if (!start_cnt_q) begin
                        start_cnt_d  = 1'b1;
                        core_start_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state_d = S_DONE;
                    end else begin
                        cycle_count_d = cc_inc;
                        if (cc_inc == {CW{1'b1}}) begin
                            state_d = S_TIMEOUT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            load_count_q  <= '0;
            load_ovf_q    <= 1'b0;
            cycle_count_q <= '0;
            core_start_q  <= 1'b0;
            start_cnt_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            load_count_q  <= load_count_d;
            load_ovf_q    <= load_ovf_d;
            cycle_count_q <= cycle_count_d;
            core_start_q  <= core_start_d;
            start_cnt_q   <= start_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            ready_en_q    <= ready_en_d;
        end
    end

    assign im_wr_en    = wr_en_q;
    assign im_wr_addr  = wr_addr_q;
    assign im_wr_data  = wr_data_q;
    assign core_start  = core_start_q;
    assign load_count  = load_count_q;
    assign load_ovf    = load_ovf_q;
    assign cycle_count = cycle_count_q;
    assign busy        = (state_q == S_START) || (state_q == S_RUN);
    assign finished    = (state_q == S_DONE);
    assign timeout     = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a small memory (D=3) and short counter (CW=4).
// Expected writes, counts and end states come from a plain model of the loader rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_prog_loader;
    localparam int D    = 3;
    localparam int W    = 9;
    localparam int CW   = 4;
    localparam int MEM  = 1 << D;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, clear, s_valid, s_last, run_req, core_done;
    logic [W-1:0]  s_data;
    logic          s_ready, im_wr_en, core_start, load_ovf, busy, finished, timeout;
    logic [D-1:0]  im_wr_addr;
    logic [W-1:0]  im_wr_data;
    logic [D:0]    load_count;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    prog_loader #(.D(D), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .run_req(run_req),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .core_start(core_start), .core_done(core_done),
        .load_count(load_count), .load_ovf(load_ovf), .cycle_count(cycle_count),
        .busy(busy), .finished(finished), .timeout(timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model state: writes still owed by the DUT, and the last run result.
    typedef struct packed {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } wr_t;
    wr_t exp_wr[$];
    int  model_cc = 0;

    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check_eq("spurious_wr_en", 32'(im_wr_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check_eq("wr_addr", 32'(im_wr_addr), 32'(e.a));
                check_eq("wr_data", 32'(im_wr_data), 32'(e.d));
            end
        end
    end

    // Streams words with random gaps; size must not exceed MEM.
    task automatic load_prog(input logic [W-1:0] words[$], input bit last_on_final);
        int  n;
        bit  armed;
        n = words.size();
        for (int i = 0; i < n; i++) begin
            int t;
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = last_on_final && (i == n - 1);
            exp_wr.push_back({D'(i), words[i]});
            t = 0;
            while (!s_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) check_eq("ready_wait", 32'(s_ready), 32'd1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        armed = last_on_final || (n >= MEM);
        check_eq("load_count", 32'(load_count), 32'(n));
        check_eq("load_ovf", 32'(load_ovf), 32'(!last_on_final && n >= MEM));
        check_eq("ready_after_load", 32'(s_ready), 32'(!armed));
        check_eq("busy_after_load", 32'(busy), 32'd0);
        check_eq("wr_pending", 32'(exp_wr.size()), 32'd0);
    endtask

    // Runs the program; the core reports done after k RUN cycles (or at once if done_always).
    task automatic run_prog(input int k, input bit done_always);
        int  starts, runs, t, exp_cc;
        bit  exp_done;
        starts = 0; runs = 0; t = 0;
        core_done = done_always;
        run_req   = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        while (!(finished || timeout) && t < 100) begin
            if (core_start) begin
                starts++;
                if (starts == 1) check_eq("cc_cleared_in_start", 32'(cycle_count), 32'd0);
            end else if (busy) begin
                if (!done_always) core_done = (runs >= k);
                runs++;
            end
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq("run_end_wait", 32'(finished | timeout), 32'd1);
        exp_done = done_always || (k < CMAX);
        exp_cc   = done_always ? 0 : (k < CMAX ? k : CMAX);
        model_cc = exp_cc;
        check_eq("start_pulse_len", 32'(starts), 32'd2);
        check_eq("finished", 32'(finished), 32'(exp_done));
        check_eq("timeout", 32'(timeout), 32'(!exp_done));
        check_eq("cycle_count", 32'(cycle_count), 32'(exp_cc));
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("cycle_count_frozen", 32'(cycle_count), 32'(exp_cc));
        check_eq("core_start_idle", 32'(core_start), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check_eq("ready_drops_on_clear", 32'(s_ready), 32'd0);
        @(negedge clk);
        clear   = 1'b0;
        s_valid = 1'b0;
        run_req = 1'b0;
        #1;
        check_eq("clr_load_count", 32'(load_count), 32'd0);
        check_eq("clr_load_ovf", 32'(load_ovf), 32'd0);
        check_eq("clr_core_start", 32'(core_start), 32'd0);
        check_eq("clr_busy", 32'(busy | finished | timeout), 32'd0);
        check_eq("clr_cc_held", 32'(cycle_count), 32'(model_cc));
        check_eq("clr_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] agg;
        agg = 32'(s_ready) | 32'(im_wr_en) | 32'(im_wr_addr) | 32'(im_wr_data) | 32'(core_start)
            | 32'(load_count) | 32'(load_ovf) | 32'(cycle_count) | 32'(busy) | 32'(finished)
            | 32'(timeout);
        check_eq(tag, agg, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q[$];
        reset = 1'b0; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        run_req = 1'b0; core_done = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 32'(s_ready), 32'd1);

        // Directed program, then run with 7 busy cycles, then done held high.
        q = '{9'h1A0, 9'h041, 9'h1FF};
        load_prog(q, 1'b1);
        run_prog(7, 1'b0);
        run_prog(0, 1'b1);

        // clear together with run_req in ARMED.
        do_clear();
        q = '{9'h003, 9'h0AA};
        load_prog(q, 1'b1);
        run_req = 1'b1;
        do_clear();

        // Fill memory without s_last, then try a 9th word.
        q.delete();
        for (int i = 0; i < MEM; i++) q.push_back(W'($urandom));
        load_prog(q, 1'b0);
        s_valid = 1'b1; s_data = 9'h155;
        repeat (3) begin
            check_eq("ovf_ready_low", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        run_prog(20, 1'b0);
        run_prog(3, 1'b0);

        // clear colliding with a stream beat mid-LOAD: the beat must not be written.
        do_clear();
        q = '{9'h011, 9'h022};
        load_prog(q, 1'b0);
        s_valid = 1'b1; s_data = 9'h033;
        do_clear();

        // Randomized programs and runs.
        for (int it = 0; it < 10; it++) begin
            int  n;
            bit  last;
            n = $urandom_range(1, MEM);
            last = (n < MEM) ? 1'b1 : 1'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(W'($urandom));
            load_prog(q, last);
            run_prog($urandom_range(0, 20), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) run_prog($urandom_range(0, 20), 1'b0);
            do_clear();
        end

        // Asynchronous reset in the middle of a run.
        q = '{9'h100, 9'h0FF};
        load_prog(q, 1'b1);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clk);
        check_eq("start_low_in_reset", 32'(core_start), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rerelease", 32'(s_ready), 32'd1);
        check_eq("idle_after_reset", 32'(busy | finished | timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
